sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Upstream stage of sha256_top. Takes a message as a 32-bit big-endian word stream and emits
//  FIPS 180-4 padded 512-bit blocks: 0x80 marker, zero fill, 64-bit big-endian bit length.
//  Its block port drives sha256_top's data_in/start through a valid/ready handshake.
//  block_first tells the hash core to load the initial H0..H7. block_last marks the final digest block.
// PARAMETERS
//  LEN_W  64  width of the message bit-length counter; zero-extended into the 64-bit length field
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous, active-high reset
//  s_data       in   32   message word, big-endian; valid bytes are left-justified
//  s_nbytes     in   3    valid bytes in s_data: 1..4, or 0 only with s_last (empty message)
//  s_last       in   1    current word is the final word of the message
//  s_valid      in   1    s_data/s_nbytes/s_last are valid
//  s_ready      out  1    padder can accept a word
//  block_out    out  512  padded block; word 0 is in [511:480]
//  block_valid  out  1    block_out is valid
//  block_ready  in   1    downstream accepts the block
//  block_first  out  1    block is the first block of its message
//  block_last   out  1    block is the final block of its message
//  err          out  1    sticky protocol error; present only with SHA256_PADDER_ERR_EN
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: s_ready=1, block_valid=0, block_first=0, block_last=0, block_out=0, err=0.
//  Internal reset state: widx=0, len=0, first_pending=1, state=FILL.
//  Reset mid-message or mid-handshake discards all state; any held block is dropped without completing.
//  Input transfer occurs when s_valid && s_ready. While s_ready=0, s_valid is ignored.
//  Output transfer occurs when block_valid && block_ready.
//  While block_valid=1 and block_ready=0, block_out/block_first/block_last are held stable.
//  FSM:
//   FILL:  s_ready=1. Each accepted word is written to word widx; len += 8*s_nbytes; widx++.
//          Non-last word with widx==15 -> EMIT.
//          s_last: let p = 4*widx + s_nbytes (bytes used); zero the unused bytes; put 0x80 at byte p.
//            p<=55: write len into words 14..15, block_last=1 -> EMIT.
//            56<=p<=63: zero the rest -> EMIT, then EXTRA.
//            p==64 (widx 15, 4 bytes): the 0x80 moves to word 0 of the EXTRA block -> EMIT, then EXTRA.
//   EMIT:  s_ready=0, block_valid=1. On transfer: first_pending=0. Then:
//            final block just sent -> first_pending=1, len=0, widx=0, state FILL;
//            EXTRA pending -> EXTRA;
//            otherwise -> FILL, widx=0.
//   EXTRA: build the block in one cycle: 0x80000000 in word 0 only when p==64, zeros, len in words 14..15;
//          block_last=1 -> EMIT.
//  block_first = first_pending, latched when the block enters EMIT.
//  Latency: block_valid rises the cycle after the completing word is accepted.
//  The EXTRA block is valid 2 cycles after the previous block's transfer.
//  Throughput: 16 words per block, plus 1 turnaround cycle per block.
//  len wraps modulo 2^LEN_W; no overflow flag.
//  A message of exactly 16*k words needs s_last on its final full word; that case is p==64.
// CONFIGURATION
//  SHA256_PADDER_ERR_EN defined:
//   err is set, and stays set until rst, on either: s_nbytes>4, or s_nbytes==0 without s_last.
//   The offending word is still accepted; s_nbytes is clamped to 4.
//  SHA256_PADDER_ERR_EN undefined:
//   err port and its logic are absent; illegal s_nbytes values are don't-care.
// STRUCTURE
//  sha256_pkg: BLOCK_W=512, WORD_W=32, PAD_BYTE=8'h80, LEN_FIELD_W=64, padder state enum {FILL,EMIT,EXTRA}.
//  Sub-module sha256_pad_word: combinational. Inputs (s_data, nbytes, insert_marker); output is the
//  masked word with 0x80 inserted. Instantiated once, for the final word.
// TESTING
//  1 "abc": 0x61626300, nbytes=3, last -> one block: 0x61626380, 14x0, 0x00000018; first=1, last=1.
//  2 Empty: nbytes=0, last -> one block: 0x80000000, 14x0, 0x00000000; first=1, last=1.
//  3 56-byte "abcdbcde...nopq" (last word 0x6e6f7071, nbytes=4) -> two blocks:
//      blk0 = data words, 0x80000000, 0; first=1, last=0.
//      blk1 = 15x0, 0x000001c0; first=0, last=1.
//  4 64 bytes of 0xFF, last on word 15 -> blk0 all-ones (last=0);
//      blk1 = 0x80000000, 14x0, 0x00000200 (last=1).
//  5 Backpressure: hold block_ready=0 for 10 cycles -> block_out stable, s_ready=0.
//      Release -> exactly one transfer, then s_ready=1 the next cycle.
//  6 rst=1 for 1 cycle after 5 words of a message -> block_valid=0.
//      The next message "abc" gives test 1's block with first=1 and len 0x18.
//      With SHA256_PADDER_ERR_EN: nbytes=5 -> err=1, held until rst.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
//  Shared constants and padder FSM encodings for the SHA-256 message path.
//  Contents: block/word/length-field widths, padding marker byte, padder
//  state codes (FILL, EMIT, EXTRA).
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int WORD_W      = 32;
  localparam int LEN_FIELD_W = 64;
  localparam int BLOCK_WORDS = BLOCK_W / WORD_W;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Padder FSM state codes
  typedef logic [1:0] pad_state_t;
  localparam pad_state_t ST_FILL  = 2'd0;
  localparam pad_state_t ST_EMIT  = 2'd1;
  localparam pad_state_t ST_EXTRA = 2'd2;

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word
//  Combinational padding of the final message word: bytes beyond nbytes are
//  zeroed and, when insert_marker is set, the 0x80 marker is placed in the
//  first unused byte (if nbytes==4 there is no room and no marker is placed).
// Ports:
//  data          in  32  message word, big-endian, valid bytes left-justified
//  nbytes        in  3   valid bytes (0..4)
//  insert_marker in  1   place the 0x80 marker after the last valid byte
//  word          out 32  masked word with marker
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  input  logic              insert_marker,
  output logic [WORD_W-1:0] word
);

  // Byte lane 0 is the most significant byte of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [2:0] LANE = 3'(gi);
    assign word[WORD_W-1-8*gi -: 8] =
        (LANE < nbytes)                    ? data[WORD_W-1-8*gi -: 8] :
        (insert_marker && LANE == nbytes)  ? PAD_BYTE :
                                             8'h00;
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//  Converts a 32-bit big-endian message word stream into FIPS 180-4 padded
//  512-bit blocks (0x80 marker, zero fill, 64-bit big-endian bit length) and
//  presents them on a valid/ready block port for the hash core.
//  Optional feature macro: SHA256_PADDER_ERR_EN adds the sticky err output.
// Ports:
//  clk, rst                       clock and synchronous active-high reset
//  s_data/s_nbytes/s_last/s_valid message word input, s_ready back-pressure
//  block_out/block_valid          padded block, word 0 in [511:480]
//  block_ready                    downstream accepts the block
//  block_first/block_last         first / final block of the message
//  err                            sticky protocol error (feature macro only)
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data,
  input  logic [2:0]         s_nbytes,
  input  logic               s_last,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_first,
  output logic               block_last
`ifdef SHA256_PADDER_ERR_EN
  ,
  output logic               err
`endif
);

  localparam logic [WORD_W-1:0] MARKER_WORD = {PAD_BYTE, 24'h000000};

  pad_state_t       state_reg;
  logic [3:0]       widx_reg;
  logic [LEN_W-1:0] len_reg;
  logic             first_pending_reg;
  logic             first_reg;
  logic             last_reg;
  logic             extra_pending_reg;
  logic             marker_extra_reg;   // 0x80 belongs in word 0 of the EXTRA block
  logic [WORD_W-1:0] words_reg [BLOCK_WORDS];

  logic                   accept;
  logic                   xfer;
  logic [2:0]             nbytes_eff;
  logic [LEN_W-1:0]       len_next;
  logic [LEN_FIELD_W-1:0] len_field_next;
  logic [LEN_FIELD_W-1:0] len_field_cur;
  logic                   short_msg;
  logic                   full_tail;
  logic [WORD_W-1:0]      padded_word;

  assign s_ready     = (state_reg == ST_FILL);
  assign block_valid = (state_reg == ST_EMIT);
  assign block_first = first_reg;
  assign block_last  = last_reg;

  assign accept = s_valid && (state_reg == ST_FILL);
  assign xfer   = (state_reg == ST_EMIT) && block_ready;

  // Illegal byte counts are treated as a full word.
  assign nbytes_eff     = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
  assign len_next       = len_reg + LEN_W'({nbytes_eff, 3'b000});
  assign len_field_next = LEN_FIELD_W'(len_next);
  assign len_field_cur  = LEN_FIELD_W'(len_reg);

  // Bytes used p = 4*widx + nbytes; p <= 55 leaves room for the length field.
  assign short_msg = (widx_reg < 4'd13) || ((widx_reg == 4'd13) && (nbytes_eff != 3'd4));
  // p == 64: the block is full of data, the marker spills into the EXTRA block.
  assign full_tail = (widx_reg == 4'd15) && (nbytes_eff == 3'd4);

  sha256_pad_word u_pad_word (
    .data          (s_data),
    .nbytes        (nbytes_eff),
    .insert_marker (1'b1),
    .word          (padded_word)
  );

  // Block buffer: cleared on every block transfer so zero fill comes for free.
  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
    localparam logic [4:0] IDX    = 5'(gi);
    localparam bit         LEN_HI = (gi == BLOCK_WORDS - 2);
    localparam bit         LEN_LO = (gi == BLOCK_WORDS - 1);
    localparam bit         WORD0  = (gi == 0);

    always_ff @(posedge clk) begin
      if (rst) begin
        words_reg[gi] <= '0;
      end else if (xfer) begin
        words_reg[gi] <= '0;
      end else if (accept) begin
        if ({1'b0, widx_reg} == IDX) begin
          words_reg[gi] <= s_last ? padded_word : s_data;
        end else if (s_last && (nbytes_eff == 3'd4) && ({1'b0, widx_reg} + 5'd1 == IDX)) begin
          // Final word was full: marker opens the following word.
          words_reg[gi] <= MARKER_WORD;
        end else if (s_last && short_msg && LEN_HI) begin
          words_reg[gi] <= len_field_next[LEN_FIELD_W-1:WORD_W];
        end else if (s_last && short_msg && LEN_LO) begin
          words_reg[gi] <= len_field_next[WORD_W-1:0];
        end
      end else if (state_reg == ST_EXTRA) begin
        if (WORD0 && marker_extra_reg) begin
          words_reg[gi] <= MARKER_WORD;
        end else if (LEN_HI) begin
          words_reg[gi] <= len_field_cur[LEN_FIELD_W-1:WORD_W];
        end else if (LEN_LO) begin
          words_reg[gi] <= len_field_cur[WORD_W-1:0];
        end
      end
    end

    assign block_out[BLOCK_W-1-WORD_W*gi -: WORD_W] = words_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_FILL;
      widx_reg          <= '0;
      len_reg           <= '0;
      first_pending_reg <= 1'b1;
      first_reg         <= 1'b0;
      last_reg          <= 1'b0;
      extra_pending_reg <= 1'b0;
      marker_extra_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            len_reg <= len_next;
            if (s_last) begin
              state_reg         <= ST_EMIT;
              first_reg         <= first_pending_reg;
              last_reg          <= short_msg;
              extra_pending_reg <= !short_msg;
              marker_extra_reg  <= full_tail;
            end else if (widx_reg == 4'd15) begin
              state_reg         <= ST_EMIT;
              first_reg         <= first_pending_reg;
              last_reg          <= 1'b0;
              extra_pending_reg <= 1'b0;
            end else begin
              widx_reg <= widx_reg + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            first_pending_reg <= 1'b0;
            widx_reg          <= '0;
            if (last_reg) begin
              // Message complete: ready for the next one.
              first_pending_reg <= 1'b1;
              len_reg           <= '0;
              state_reg         <= ST_FILL;
            end else if (extra_pending_reg) begin
              state_reg <= ST_EXTRA;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        ST_EXTRA: begin
          state_reg         <= ST_EMIT;
          first_reg         <= first_pending_reg;
          last_reg          <= 1'b1;
          extra_pending_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_FILL;
        end
      endcase
    end
  end

`ifdef SHA256_PADDER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && ((s_nbytes > 3'd4) || ((s_nbytes == 3'd0) && !s_last))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder
//  Directed self-checking bench for sha256_msg_padder using immediate
//  assertions against hand-computed padded blocks.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_data = '0;
  logic [2:0]   s_nbytes = '0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic         block_first;
  logic         block_last;
`ifdef SHA256_PADDER_ERR_EN
  logic         err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_nbytes    (s_nbytes),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last)
`ifdef SHA256_PADDER_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input logic [511:0] obs, input logic [511:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    n = 0;
    s_data   = d;
    s_nbytes = nb;
    s_last   = last;
    s_valid  = 1'b1;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check(512'(s_ready), 512'(1), "s_ready_wait");
    step();
    s_valid = 1'b0;
    $display("word %08h nbytes=%0d last=%0d accepted", d, nb, last);
  endtask

  task automatic take_block(input logic [511:0] exp, input logic f, input logic l, input string tag);
    int n;
    n = 0;
    while (!block_valid && n < 100) begin
      step();
      n++;
    end
    check(512'(block_valid), 512'(1), {tag, "_valid"});
    check(block_out, exp, {tag, "_data"});
    check(512'(block_first), 512'(f), {tag, "_first"});
    check(512'(block_last), 512'(l), {tag, "_last"});
    block_ready = 1'b1;
    step();
    block_ready = 1'b0;
    $display("block %s first=%0b last=%0b taken", tag, block_first, block_last);
  endtask

  logic [511:0] exp;
  logic [511:0] held;
  logic [7:0]   b;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    check(512'(s_ready), 512'(1), "rst_s_ready");
    check(512'(block_valid), 512'(0), "rst_block_valid");
    check(512'(block_first), 512'(0), "rst_block_first");
    check(512'(block_last), 512'(0), "rst_block_last");
    check(block_out, 512'(0), "rst_block_out");
`ifdef SHA256_PADDER_ERR_EN
    check(512'(err), 512'(0), "rst_err");
`endif
    rst = 1'b0;
    step();

    // Test 1: "abc", block valid the cycle after the word is accepted
    send_word(32'h61626300, 3'd3, 1'b1);
    check(512'(block_valid), 512'(1), "t1_latency");
    exp = '0;
    exp[511 -: 32] = 32'h61626380;
    exp[31:0]      = 32'h00000018;
    take_block(exp, 1'b1, 1'b1, "t1_abc");
    check(512'(s_ready), 512'(1), "t1_s_ready_after");

    // Test 2: empty message
    send_word(32'h00000000, 3'd0, 1'b1);
    exp = '0;
    exp[511 -: 32] = 32'h80000000;
    take_block(exp, 1'b1, 1'b1, "t2_empty");

    // Test 3: 56-byte message, length spills into a second block
    exp = '0;
    for (int i = 0; i < 14; i++) begin
      b = 8'h61 + 8'(i);
      exp[511-32*i -: 32] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      send_word({b, b + 8'd1, b + 8'd2, b + 8'd3}, 3'd4, (i == 13));
    end
    exp[511-32*14 -: 32] = 32'h80000000;
    check(exp[511-32*13 -: 32], 512'(32'h6e6f7071), "t3_vector_last_word");
    take_block(exp, 1'b1, 1'b0, "t3_blk0");
    exp = '0;
    exp[31:0] = 32'h000001c0;
    take_block(exp, 1'b0, 1'b1, "t3_blk1");

    // Test 4: 64 bytes of 0xFF, marker moves into the EXTRA block
    for (int i = 0; i < 16; i++) send_word(32'hFFFFFFFF, 3'd4, (i == 15));
    exp = '1;
    take_block(exp, 1'b1, 1'b0, "t4_blk0");
    check(512'(block_valid), 512'(0), "t4_extra_gap");
    step();
    check(512'(block_valid), 512'(1), "t4_extra_timing");
    exp = '0;
    exp[511 -: 32] = 32'h80000000;
    exp[31:0]      = 32'h00000200;
    take_block(exp, 1'b0, 1'b1, "t4_blk1");

    // Test 5: backpressure holds the block and stalls the input
    send_word(32'h61626300, 3'd3, 1'b1);
    held = block_out;
    exp = '0;
    exp[511 -: 32] = 32'h61626380;
    exp[31:0]      = 32'h00000018;
    check(held, exp, "t5_block");
    for (int i = 0; i < 10; i++) begin
      step();
      check(block_out, held, "t5_hold_data");
      check(512'(s_ready), 512'(0), "t5_hold_s_ready");
      check(512'(block_valid), 512'(1), "t5_hold_valid");
    end
    block_ready = 1'b1;
    step();
    block_ready = 1'b0;
    check(512'(block_valid), 512'(0), "t5_one_transfer");
    check(512'(s_ready), 512'(1), "t5_s_ready_after");

    // Test 6: reset mid-message discards state
    for (int i = 0; i < 5; i++) send_word(32'h11223344, 3'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check(512'(block_valid), 512'(0), "t6_rst_valid");
    check(512'(s_ready), 512'(1), "t6_rst_s_ready");
    send_word(32'h61626300, 3'd3, 1'b1);
    exp = '0;
    exp[511 -: 32] = 32'h61626380;
    exp[31:0]      = 32'h00000018;
    take_block(exp, 1'b1, 1'b1, "t6_abc");

`ifdef SHA256_PADDER_ERR_EN
    // Illegal byte count sets the sticky error
    send_word(32'hAABBCCDD, 3'd5, 1'b0);
    check(512'(err), 512'(1), "err_set");
    send_word(32'h01020304, 3'd4, 1'b0);
    check(512'(err), 512'(1), "err_sticky");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check(512'(err), 512'(0), "err_clear");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
